// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save select result path.
// Stages that size themselves off the select/MAC result width import this package.
package csa_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        DONE    = 2'd2
    } csa_acc_state_e;

    // A sum of len values, each bw bits wide, fits in bw + clog2(len) bits.
    function automatic int acc_width(input int bw, input int len);
        return bw + $clog2(len);
    endfunction

endpackage

// File: rtl/csa_out_reg.sv
// Valid/ready holding register for a completed frame sum and its sample count.
// A load is only issued when the slot is empty or draining this cycle.
module csa_out_reg #(
    parameter int SUM_W = 10,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SUM_W-1:0] load_sum,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    logic             valid_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            sum_reg   <= '0;
            count_reg <= '0;
        end else if (load) begin
            // A new frame replaces the one leaving in the same cycle.
            valid_reg <= 1'b1;
            sum_reg   <= load_sum;
            count_reg <= load_count;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_count = count_reg;

endmodule

// File: rtl/csa_result_accumulator.sv
// Sums consecutive select/MAC results into frames of up to LEN samples and
// presents each frame sum and sample count on a valid/ready output.
module csa_result_accumulator
    import csa_pkg::*;
#(
    parameter int BW    = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = acc_width(BW, LEN),
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW-1:0]    in_res,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    csa_acc_state_e state_reg, state_next;

    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ACC_W-1:0] res_ext;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             close;
    logic             transfer;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Gate on in_valid so an undriven in_res never reaches the accumulator.
    assign res_ext  = in_valid ? ACC_W'(in_res) : '0;
    assign sum_next = acc_reg + res_ext;
    assign cnt_inc  = cnt_reg + CNT_W'(1);
    assign close    = accept && (in_last || (cnt_inc == CNT_W'(LEN)));

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (close) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (accept) begin
            acc_next = sum_next;
            cnt_next = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= EMPTY;
        end else begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            EMPTY: begin
                if (close)       state_next = DONE;
                else if (accept) state_next = PARTIAL;
            end
            PARTIAL: begin
                if (close) state_next = DONE;
            end
            DONE: begin
                // Accepts only happen here alongside a transfer.
                if (transfer) begin
                    if (close)       state_next = DONE;
                    else if (accept) state_next = PARTIAL;
                    else             state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    csa_out_reg #(
        .SUM_W(ACC_W),
        .CNT_W(CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (close),
        .load_sum   (sum_next),
        .load_count (cnt_inc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_sum    (out_sum),
        .out_count  (out_count)
    );

endmodule
